// File: rtl/symbol_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module     : symbol_capture_buffer
// Description: I/Q symbol capture RAM on the symbol clock domain. Stores
//              {I,Q} words from the 64-QAM mapper while armed, in one-shot
//              (stop when full) or circular (overwrite oldest) mode, and
//              offers a registered random-access read port for the SPI
//              register front end.
// Ports      : sym_clk    - symbol clock, rising-edge
//              rst_n_sym  - asynchronous active-low reset
//              arm        - pulse: clear pointers, start capture
//              stop       - pulse: end capture
//              circ_mode  - 0 one-shot, 1 circular (sampled on arm)
//              iq_valid   - symbol strobe, I_data/Q_data written in CAPTURE
//              I_data/Q_data - symbol components
//              rd_req/rd_addr - read request and address
//              rd_data/rd_valid - read data {I,Q}, valid one cycle later
//              wr_count   - stored symbols, saturates at DEPTH
//              capturing/full/wrapped - status
// Config     : define SYMCAP_LOGICAL_ADDR_EN to make rd_addr a logical
//              index from the oldest stored symbol (index 0 = oldest).
//              Undefined: rd_addr is the physical RAM address.
// Revision   : 1.0 - initial release
// ============================================================================
module symbol_capture_buffer #(
  parameter int IQ_W   = 4,
  parameter int ADDR_W = 9
) (
  input  logic                sym_clk,
  input  logic                rst_n_sym,
  input  logic                arm,
  input  logic                stop,
  input  logic                circ_mode,
  input  logic                iq_valid,
  input  logic [IQ_W-1:0]     I_data,
  input  logic [IQ_W-1:0]     Q_data,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [2*IQ_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [ADDR_W:0]     wr_count,
  output logic                capturing,
  output logic                full,
  output logic                wrapped
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int WORD_W = 2*IQ_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                wrapped_q, wrapped_d;
  logic                circ_q, circ_d;
  logic [WORD_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [ADDR_W-1:0]   w_rd_phys;

  logic [WORD_W-1:0]   mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge sym_clk or negedge rst_n_sym) begin
    if (!rst_n_sym) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wr_count_q <= '0;
      wrapped_q  <= 1'b0;
      circ_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_count_q <= wr_count_d;
      wrapped_q  <= wrapped_d;
      circ_q     <= circ_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and write control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    wr_count_d = wr_count_q;
    wrapped_d  = wrapped_q;
    circ_d     = circ_q;
    w_we       = 1'b0;
    w_waddr    = wr_ptr_q;

    if (arm) begin
      // Arm restarts from any state and beats a coincident stop. A symbol
      // arriving with arm is the first entry of the new capture.
      state_d   = S_CAPTURE;
      circ_d    = circ_mode;
      wrapped_d = 1'b0;
      w_waddr   = '0;
      if (iq_valid) begin
        w_we       = 1'b1;
        wr_ptr_d   = ADDR_W'(1);
        wr_count_d = (ADDR_W+1)'(1);
      end else begin
        wr_ptr_d   = '0;
        wr_count_d = '0;
      end
    end else if (state_q == S_CAPTURE) begin
      if (iq_valid) begin
        w_we     = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (wr_count_q == DEPTH_CNT) begin
          // Only reachable in circular mode: this write replaces the oldest.
          wrapped_d = circ_q;
        end else begin
          wr_count_d = wr_count_q + (ADDR_W+1)'(1);
          if (!circ_q && (wr_count_q == DEPTH_CNT - (ADDR_W+1)'(1))) begin
            state_d = S_DONE;
          end
        end
      end
      // A stop alongside a symbol still keeps that symbol.
      if (stop) begin
        state_d = S_DONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture RAM (contents are not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge sym_clk) begin
    if (w_we) begin
      mem_q[w_waddr] <= {I_data, Q_data};
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
`ifdef SYMCAP_LOGICAL_ADDR_EN
  // Once wrapped, the oldest entry sits at wr_ptr; the sum wraps mod DEPTH.
  assign w_rd_phys = wrapped_q ? (wr_ptr_q + rd_addr) : rd_addr;
`else
  assign w_rd_phys = rd_addr;
`endif

  // Read-before-write: a same-edge write to the read address is not seen.
  always_ff @(posedge sym_clk or negedge rst_n_sym) begin
    if (!rst_n_sym) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        rd_data_q <= mem_q[w_rd_phys];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_count  = wr_count_q;
  assign capturing = (state_q == S_CAPTURE);
  assign full      = (wr_count_q == DEPTH_CNT);
  assign wrapped   = wrapped_q;

endmodule
`default_nettype wire

// File: tb/tb_symbol_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module     : tb_symbol_capture_buffer
// Description: Self-checking bench for symbol_capture_buffer. A sequence-
//              level model (count of symbols since arm, written-symbol
//              array) predicts every output on every cycle; directed
//              literal checks pin the model. A second, small instance
//              (IQ_W=6, ADDR_W=4) is checked with literals only.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_symbol_capture_buffer;

  localparam int IQ_W   = 4;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       arm = 0, stop = 0, circ_mode = 0, iq_valid = 0, rd_req = 0;
  logic [3:0] I_data = 0, Q_data = 0;
  logic [8:0] rd_addr = 0;
  logic [7:0] rd_data;
  logic       rd_valid, capturing, full, wrapped;
  logic [9:0] wr_count;

  logic        s_arm = 0, s_stop = 0, s_circ = 0, s_iq_valid = 0, s_rd_req = 0;
  logic [5:0]  s_I = 0, s_Q = 0;
  logic [3:0]  s_rd_addr = 0;
  logic [11:0] s_rd_data;
  logic        s_rd_valid, s_capturing, s_full, s_wrapped;
  logic [4:0]  s_wr_count;

  always #5 clk = ~clk;

  symbol_capture_buffer #(.IQ_W(IQ_W), .ADDR_W(ADDR_W)) u_dut (
    .sym_clk(clk), .rst_n_sym(rst_n), .arm(arm), .stop(stop),
    .circ_mode(circ_mode), .iq_valid(iq_valid), .I_data(I_data),
    .Q_data(Q_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_count(wr_count),
    .capturing(capturing), .full(full), .wrapped(wrapped)
  );

  symbol_capture_buffer #(.IQ_W(6), .ADDR_W(4)) u_small (
    .sym_clk(clk), .rst_n_sym(rst_n), .arm(s_arm), .stop(s_stop),
    .circ_mode(s_circ), .iq_valid(s_iq_valid), .I_data(s_I),
    .Q_data(s_Q), .rd_req(s_rd_req), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .wr_count(s_wr_count),
    .capturing(s_capturing), .full(s_full), .wrapped(s_wrapped)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: symbols since the last arm, in arrival order. Stored position of
  // symbol n is n mod DEPTH; capture ends at DEPTH symbols in one-shot mode.
  // --------------------------------------------------------------------------
  int         m_total = 0;
  bit         m_circ = 0, m_cap = 0;
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  logic [7:0] m_rd_data = 8'h00;
  bit         m_rd_valid = 0, m_rd_known = 1;
  int         m_phys;

  function automatic int m_count();
    return (m_total > DEPTH) ? DEPTH : m_total;
  endfunction

  function automatic bit m_wrapped();
    return m_circ && (m_total > DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_total = 0; m_cap = 0; m_circ = 0;
      m_rd_data = 8'h00; m_rd_valid = 0; m_rd_known = 1;
    end else begin
      if (rd_req) begin
        m_phys = int'(rd_addr);
`ifdef SYMCAP_LOGICAL_ADDR_EN
        if (m_wrapped()) m_phys = (m_total + int'(rd_addr)) % DEPTH;
`endif
        m_rd_data  = m_mem[m_phys];
        m_rd_known = m_known[m_phys];
        m_rd_valid = 1;
      end else begin
        m_rd_valid = 0;
      end
      if (arm) begin
        m_total = 0; m_circ = circ_mode; m_cap = 1;
        if (iq_valid) begin
          m_mem[0] = {I_data, Q_data}; m_known[0] = 1; m_total = 1;
        end
      end else if (m_cap) begin
        if (iq_valid) begin
          m_mem[m_total % DEPTH] = {I_data, Q_data};
          m_known[m_total % DEPTH] = 1;
          m_total++;
          if (!m_circ && m_total == DEPTH) m_cap = 0;
        end
        if (stop) m_cap = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("capturing", 32'(capturing), 32'(m_cap));
    chk("wr_count", 32'(wr_count), 32'(m_count()));
    chk("full", 32'(full), 32'(m_count() == DEPTH));
    chk("wrapped", 32'(wrapped), 32'(m_wrapped()));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd_data));
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change only after the falling edge.
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_arm(input logic c);
    arm = 1; circ_mode = c; cyc(); arm = 0;
  endtask

  task automatic wr(input logic [7:0] v);
    iq_valid = 1; I_data = v[7:4]; Q_data = v[3:0]; cyc(); iq_valid = 0;
  endtask

  task automatic rd(input logic [8:0] a);
    rd_req = 1; rd_addr = a; cyc(); rd_req = 0;
  endtask

  task automatic s_wr(input logic [5:0] i, input logic [5:0] q);
    s_iq_valid = 1; s_I = i; s_Q = q; cyc(); s_iq_valid = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cyc(); cyc();
    #2 rst_n = 1'b1;
    cyc();

    // T1: reset mid-capture
    do_arm(0);
    for (int k = 0; k < 4; k++) wr(8'(k + 8'h50));
    chk("t1_pre_count", 32'(wr_count), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_capturing", 32'(capturing), 32'd0);
    chk("t1_rst_count", 32'(wr_count), 32'd0);
    chk("t1_rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    arm = 1; circ_mode = 0; iq_valid = 1; I_data = 4'hA; Q_data = 4'hB;
    cyc(); arm = 0; iq_valid = 0;
    chk("t1_arm_write_count", 32'(wr_count), 32'd1);
    chk("t1_arm_capturing", 32'(capturing), 32'd1);
    rd(9'd0);
    chk("t1_rd0", 32'(rd_data), 32'hAB);

    // T2: one-shot fill
    do_arm(0);
    for (int k = 0; k < DEPTH; k++) wr(8'(k));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_done", 32'(capturing), 32'd0);
    wr(8'hFF);
    chk("t2_ignored_count", 32'(wr_count), 32'd512);
    rd(9'd5);
    chk("t2_rd5_valid", 32'(rd_valid), 32'd1);
    chk("t2_rd5", 32'(rd_data), 32'h05);
    rd(9'd0);
    chk("t2_rd0_not_overwritten", 32'(rd_data), 32'h00);
    cyc();
    chk("t2_rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("t2_rd_data_hold", 32'(rd_data), 32'h00);

    // T3: circular, 520 symbols
    do_arm(1);
    for (int k = 0; k < 520; k++) wr(8'(k));
    chk("t3_wrapped", 32'(wrapped), 32'd1);
    chk("t3_count", 32'(wr_count), 32'd512);
    chk("t3_capturing", 32'(capturing), 32'd1);
`ifdef SYMCAP_LOGICAL_ADDR_EN
    rd(9'd0);
    chk("t3_logical0", 32'(rd_data), 32'h08);
    rd(9'd3);
    chk("t3_logical3", 32'(rd_data), 32'h0B);
`else
    rd(9'd7);
    chk("t3_phys7", 32'(rd_data), 32'h07);
    rd(9'd3);
    chk("t3_phys3", 32'(rd_data), 32'h03);
`endif

    // T4: stop, with the last symbol arriving alongside stop
    do_arm(0);
    for (int k = 0; k < 9; k++) wr(8'(8'h40 + k));
    stop = 1; wr(8'h49); stop = 0;
    chk("t4_done", 32'(capturing), 32'd0);
    chk("t4_count", 32'(wr_count), 32'd10);
    for (int k = 0; k < 3; k++) wr(8'hEE);
    chk("t4_ignored_count", 32'(wr_count), 32'd10);
    rd(9'd9);
    chk("t4_rd9", 32'(rd_data), 32'h49);

    // T5: arm+stop, then read/write collision
    arm = 1; stop = 1; circ_mode = 0; cyc(); arm = 0; stop = 0;
    chk("t5_arm_beats_stop", 32'(capturing), 32'd1);
    wr(8'h20); wr(8'h21); wr(8'h22);
    do_arm(0);
    wr(8'h30); wr(8'h31);
    rd_req = 1; rd_addr = 9'd2;
    wr(8'h32);
    rd_req = 0;
    chk("t5_collision_old", 32'(rd_data), 32'h22);
    rd(9'd2);
    chk("t5_new", 32'(rd_data), 32'h32);

    // T6: small instance, 16-deep, 12-bit words
    s_arm = 1; cyc(); s_arm = 0;
    for (int k = 0; k < 16; k++) begin
      s_wr(6'(k), 6'(63 - k));
      if (k == 14) begin
        chk("t6_not_full_15", 32'(s_full), 32'd0);
        chk("t6_capturing_15", 32'(s_capturing), 32'd1);
      end
    end
    chk("t6_full", 32'(s_full), 32'd1);
    chk("t6_done", 32'(s_capturing), 32'd0);
    chk("t6_count", 32'(s_wr_count), 32'd16);
    s_wr(6'h3F, 6'h3F);
    chk("t6_ignored_count", 32'(s_wr_count), 32'd16);
    s_rd_req = 1; s_rd_addr = 4'd15; cyc(); s_rd_req = 0;
    chk("t6_rd15", 32'(s_rd_data), 32'({6'd15, 6'd48}));
    chk("t6_rd_valid", 32'(s_rd_valid), 32'd1);
    s_rd_req = 1; s_rd_addr = 4'd0; cyc(); s_rd_req = 0;
    chk("t6_rd0", 32'(s_rd_data), 32'({6'd0, 6'd63}));

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
